// File: rtl/conv_window_fetcher_if.sv
// conv_window_fetcher_if: bus bundle between the window fetcher, the image
// RAM port and the convolution datapath.
//   ram_*  : single-port RAM (w_en/r_en, address, write data, registered read data)
//   win_*  : 3x3 window handoff (valid/ready, 72-bit pixels, top-left row/col)
//   res_*  : per-window 8-bit result handoff (valid/ready, data)
// master = the fetcher, slave = RAM + datapath side.
interface conv_window_fetcher_if #(
  parameter int ADDR_W = 12
);
  logic              ram_w_en;
  logic              ram_r_en;
  logic [ADDR_W-1:0] ram_address;
  logic [7:0]        ram_data_in;
  logic [7:0]        ram_data_out;

  logic              win_valid;
  logic              win_ready;
  logic [71:0]       win_data;
  logic [7:0]        win_row;
  logic [7:0]        win_col;

  logic              res_valid;
  logic              res_ready;
  logic [7:0]        res_data;

  modport master (
    output ram_w_en, ram_r_en, ram_address, ram_data_in,
    input  ram_data_out,
    output win_valid, win_data, win_row, win_col,
    input  win_ready,
    input  res_valid, res_data,
    output res_ready
  );

  modport slave (
    input  ram_w_en, ram_r_en, ram_address, ram_data_in,
    output ram_data_out,
    input  win_valid, win_data, win_row, win_col,
    output win_ready,
    output res_valid, res_data,
    input  res_ready
  );
endinterface

// File: rtl/conv_window_fetcher.sv
// conv_window_fetcher: sweeps every 3x3 window of a row-major grayscale image
// held in RAM, hands each window to the convolution datapath and writes the
// returned byte to the output region (width IMG_W-2) of the same RAM.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   start       : begin a sweep (sampled only when idle)
//   busy        : high while a sweep is in progress
//   done        : one-cycle pulse after the last write-back
//   bus         : conv_window_fetcher_if.master (RAM port, window and result handshakes)
// Build option: define WIN_REUSE_EN to keep the two overlapping columns when
// stepping right, so only the three new right-hand pixels are read.
module conv_window_fetcher #(
  parameter int IMG_W    = 32,
  parameter int IMG_H    = 32,
  parameter int ADDR_W   = 12,
  parameter int IN_BASE  = 0,
  parameter int OUT_BASE = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  conv_window_fetcher_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_PRESENT, S_WAIT_RES, S_WRITE, S_DONE
  } state_t;

  state_t          state, state_nx;
  logic [7:0]      r, c;
  logic [8:0][7:0] slot;        // slot k = dy*3+dx
  logic [7:0]      res_q;
  logic [1:0]      rd_dy, rd_dx; // next read position inside the window
  logic            rd_fin;       // all reads for this window issued
  logic            reuse_win;    // current fetch only reads the dx=2 column
  logic            cap_vld;      // read issued last cycle, data arrives now
  logic [3:0]      cap_k;
  logic [3:0]      rd_k;
  logic            rd_en;
  logic            last_col, last_row;
  logic [31:0]     rd_lin, wr_lin;

  assign last_col = (c == 8'(IMG_W - 3));
  assign last_row = (r == 8'(IMG_H - 3));
  assign rd_k     = {2'b00, rd_dy} * 4'd3 + {2'b00, rd_dx};
  assign rd_en    = (state == S_FETCH) && !rd_fin;

  // Address arithmetic done wide, then truncated to the RAM width.
  assign rd_lin = 32'(IN_BASE) + (32'(r) + 32'(rd_dy)) * 32'(IMG_W) + 32'(c) + 32'(rd_dx);
  assign wr_lin = 32'(OUT_BASE) + 32'(r) * 32'(IMG_W - 2) + 32'(c);

  // Outputs decode straight from state so reset silences them immediately.
  assign bus.ram_r_en    = rd_en;
  assign bus.ram_w_en    = (state == S_WRITE);
  assign bus.ram_address = (state == S_WRITE) ? wr_lin[ADDR_W-1:0] :
                           rd_en              ? rd_lin[ADDR_W-1:0] : '0;
  assign bus.ram_data_in = (state == S_WRITE) ? res_q : 8'h00;
  assign bus.win_valid   = (state == S_PRESENT);
  assign bus.win_data    = slot;
  assign bus.win_row     = r;
  assign bus.win_col     = c;
  assign bus.res_ready   = (state == S_WAIT_RES);
  assign busy            = (state != S_IDLE) && (state != S_DONE);
  assign done            = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (start) state_nx = S_FETCH;
      // slot 8 is the last byte in both full and reuse fetch orders
      S_FETCH:    if (cap_vld && cap_k == 4'd8) state_nx = S_PRESENT;
      S_PRESENT:  if (bus.win_ready) state_nx = S_WAIT_RES;
      S_WAIT_RES: if (bus.res_valid) state_nx = S_WRITE;
      S_WRITE:    state_nx = (last_col && last_row) ? S_DONE : S_FETCH;
      S_DONE:     state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r         <= '0;
      c         <= '0;
      slot      <= '0;
      res_q     <= '0;
      rd_dy     <= '0;
      rd_dx     <= '0;
      rd_fin    <= 1'b0;
      reuse_win <= 1'b0;
      cap_vld   <= 1'b0;
      cap_k     <= '0;
    end else begin
      // one-cycle RAM latency: remember which slot the returning byte fills
      cap_vld <= rd_en;
      cap_k   <= rd_k;
      if (cap_vld) slot[cap_k] <= bus.ram_data_out;

      if (rd_en) begin
        if (rd_dx == 2'd2) begin
          rd_dx  <= reuse_win ? 2'd2 : 2'd0;
          rd_dy  <= rd_dy + 2'd1;
          rd_fin <= (rd_dy == 2'd2);
        end else begin
          rd_dx  <= rd_dx + 2'd1;
        end
      end

      case (state)
        S_IDLE: if (start) begin
          r         <= '0;
          c         <= '0;
          rd_dy     <= '0;
          rd_dx     <= '0;
          rd_fin    <= 1'b0;
          reuse_win <= 1'b0;
        end
        S_WAIT_RES: if (bus.res_valid) res_q <= bus.res_data;
        S_WRITE: begin
          rd_dy  <= '0;
          rd_fin <= 1'b0;
          if (!last_col) begin
            c <= c + 8'd1;
`ifdef WIN_REUSE_EN
            reuse_win <= 1'b1;
            rd_dx     <= 2'd2;
            for (int dy = 0; dy < 3; dy++) begin
              slot[dy*3]   <= slot[dy*3+1];
              slot[dy*3+1] <= slot[dy*3+2];
            end
`else
            reuse_win <= 1'b0;
            rd_dx     <= 2'd0;
`endif
          end else if (!last_row) begin
            c         <= '0;
            r         <= r + 8'd1;
            reuse_win <= 1'b0;
            rd_dx     <= 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
